interrupt_unit: RTL and testbench
=================================

INTERRUPT_UNIT -- requirements
Module: interrupt_unit

Interface
REQ-001 The block SHALL have parameter VECTOR_ADDR, default 32'h0000_0002: PC loaded on interrupt entry.
REQ-002 The block SHALL have parameter DRAIN_CYCLES, default 3: cycles fetch is held before pushes start; legal range 1-15.
REQ-003 The block SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1: asynchronous active-high reset.
REQ-005 The block SHALL have port int_req  input  1: external interrupt request; rising edge requests service.
REQ-006 The block SHALL have port pc_in  input  32: address of the next instruction to fetch.
REQ-007 The block SHALL have port ccr_in  input  3: current condition code register.
REQ-008 The block SHALL have port freeze_cu  input  1: pipeline is mid multi-cycle instruction; entry is not allowed.
REQ-009 The block SHALL have port rti  input  1: one-cycle pulse when RTI completes.
REQ-010 The block SHALL have port mem_busy  input  1: data memory cannot accept a stack write this cycle.
REQ-011 The block SHALL have port fetch_stall  output  1: holds the PC and injects NOPs into IF/ID.
REQ-012 The block SHALL have port push_en  output  1: stack write request.
REQ-013 The block SHALL have port push_data  output  16: stack write data.
REQ-014 The block SHALL have port pc_load  output  1: one-cycle pulse that loads the PC.
REQ-015 The block SHALL have port pc_vector  output  32: value loaded into the PC, equal to VECTOR_ADDR.
REQ-016 The block SHALL have port in_isr  output  1: service routine active; new requests are masked.

Function
REQ-017 The block SHALL register int_req and SHALL set a pending flag on each 0->1 transition, including while not IDLE.
REQ-018 The states SHALL be IDLE, DRAIN, PUSH_PCH, PUSH_PCL, PUSH_CCR, LOAD_VEC and ISR.
REQ-019 IDLE SHALL go to DRAIN when pending=1 and freeze_cu=0; the same edge SHALL capture pc_in into ret_pc and clear pending.
REQ-020 DRAIN SHALL count DRAIN_CYCLES cycles with fetch_stall=1, then go to PUSH_PCH; ccr_in SHALL be captured on its last cycle.
REQ-021 PUSH_PCH, PUSH_PCL and PUSH_CCR SHALL drive push_en=1 with data ret_pc[31:16], then ret_pc[15:0], then {13'b0, ccr}.
REQ-022 Each push SHALL advance only on a cycle with mem_busy=0; while mem_busy=1 the state, push_en and push_data SHALL hold.
REQ-023 LOAD_VEC SHALL assert pc_load for exactly 1 cycle, then go to ISR; fetch_stall SHALL be 1 in DRAIN through LOAD_VEC.
REQ-024 ISR SHALL drive in_isr=1 and fetch_stall=0; rti=1 SHALL return to IDLE on the next edge.
REQ-025 rti SHALL be ignored outside ISR.
REQ-026 A request seen during ISR SHALL stay pending and SHALL be serviced from IDLE after RTI, with no nesting.
REQ-027 When int_req rises on the same cycle that rti returns to ISR->IDLE, pending SHALL be set, and DRAIN SHALL start one cycle after IDLE is entered.
REQ-028 Request to pc_load latency SHALL be 1 (edge detect) + 1 (IDLE) + DRAIN_CYCLES + 3 + 1 cycles when freeze_cu=0 and mem_busy=0.
REQ-029 pc_vector SHALL be constant VECTOR_ADDR.
REQ-030 push_data SHALL be 16'h0000 whenever push_en=0.

Reset
REQ-031 rst=1 SHALL immediately force: state IDLE, pending 0, counter 0, ret_pc 0, captured ccr 0, and all outputs 0 except pc_vector.
REQ-032 Reset mid-sequence SHALL abandon the sequence with no further push_en or pc_load, and SHALL lose any pending request.
REQ-033 A level int_req held high through reset release SHALL NOT be treated as an edge; the registered copy resets to 0 and the request line must fall and rise again.

Verification
REQ-034 Bench: pc_in=32'h0001_2345, ccr_in=3'b101, int_req pulse, DRAIN_CYCLES=3 -> pushes 16'h0001, 16'h2345, 16'h0005 on consecutive cycles, then pc_load=1 with pc_vector=32'h0000_0002, then in_isr=1.
REQ-035 Bench: freeze_cu=1 for 4 cycles when the request arrives -> stays IDLE with fetch_stall=0 until freeze_cu falls, then the REQ-034 sequence.
REQ-036 Bench: mem_busy=1 for 2 cycles during PUSH_PCL -> push_en and push_data=16'h2345 held for 3 cycles; total latency +2.
REQ-037 Bench: second int_req edge during ISR, then rti pulse -> IDLE for 1 cycle, then a new DRAIN; no pushes before rti.
REQ-038 Bench: rst asserted in PUSH_PCL -> outputs 0 asynchronously; after release, no push_en or pc_load until a new int_req edge.
REQ-039 Bench: rti pulse while IDLE -> no state change and outputs unchanged.

Source files
------------

// File: rtl/interrupt_unit.sv
// Hardware interrupt entry sequencer: detects a request edge, drains the pipeline,
// pushes PC and CCR to the stack, vectors the PC and tracks the service routine until RTI.
module interrupt_unit #(
  parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0002,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic [31:0] pc_in,
  input  logic [2:0]  ccr_in,
  input  logic        freeze_cu,
  input  logic        rti,
  input  logic        mem_busy,
  output logic        fetch_stall,
  output logic        push_en,
  output logic [15:0] push_data,
  output logic        pc_load,
  output logic [31:0] pc_vector,
  output logic        in_isr
);

  typedef enum logic [2:0] {
    IDLE, DRAIN, PUSH_PCH, PUSH_PCL, PUSH_CCR, LOAD_VEC, ISR
  } state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  // Handshake: each push is held until a cycle with mem_busy=0 accepts it.
  state_t      state, state_n;
  logic        req_q;
  logic        armed;
  logic        pending;
  logic        rise;
  logic        enter;
  logic [3:0]  cnt;
  logic [31:0] ret_pc;
  logic [2:0]  ccr_q;

  assign pc_vector = VECTOR_ADDR;

  // armed blocks a request level held through reset from looking like an edge.
  assign rise  = int_req & ~req_q & armed;
  assign enter = (state == IDLE) && (state_n == DRAIN);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (pending && !freeze_cu) state_n = DRAIN;
      DRAIN:    if (cnt == DRAIN_LAST) state_n = PUSH_PCH;
      PUSH_PCH: if (!mem_busy) state_n = PUSH_PCL;
      PUSH_PCL: if (!mem_busy) state_n = PUSH_CCR;
      PUSH_CCR: if (!mem_busy) state_n = LOAD_VEC;
      LOAD_VEC: state_n = ISR;
      ISR:      if (rti) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_q       <= 1'b0;
      armed       <= 1'b0;
      pending     <= 1'b0;
      cnt         <= 4'd0;
      ret_pc      <= 32'd0;
      ccr_q       <= 3'd0;
      fetch_stall <= 1'b0;
      push_en     <= 1'b0;
      push_data   <= 16'h0000;
      pc_load     <= 1'b0;
      in_isr      <= 1'b0;
    end else begin
      state <= state_n;
      req_q <= int_req;
      if (!int_req) armed <= 1'b1;

      if (rise) pending <= 1'b1;
      else if (enter) pending <= 1'b0;

      if (enter) begin
        ret_pc <= pc_in;
        cnt    <= 4'd0;
      end else if (state == DRAIN) begin
        cnt <= cnt + 4'd1;
      end

      if (state == DRAIN && state_n == PUSH_PCH) ccr_q <= ccr_in;

      // Outputs are decoded from the next state so they line up with it.
      fetch_stall <= (state_n inside {DRAIN, PUSH_PCH, PUSH_PCL, PUSH_CCR, LOAD_VEC});
      push_en     <= (state_n inside {PUSH_PCH, PUSH_PCL, PUSH_CCR});
      pc_load     <= (state_n == LOAD_VEC);
      in_isr      <= (state_n == ISR);
      case (state_n)
        PUSH_PCH: push_data <= ret_pc[31:16];
        PUSH_PCL: push_data <= ret_pc[15:0];
        PUSH_CCR: push_data <= {13'b0, ccr_q};
        default:  push_data <= 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_unit.sv
// Directed bench for interrupt_unit: entry sequence, freeze, memory back-pressure,
// pending across ISR, RTI races, reset mid-sequence and held request through reset.
module tb_interrupt_unit;

  logic        clk;
  logic        rst;
  logic        int_req;
  logic [31:0] pc_in;
  logic [2:0]  ccr_in;
  logic        freeze_cu;
  logic        rti;
  logic        mem_busy;
  logic        fetch_stall;
  logic        push_en;
  logic [15:0] push_data;
  logic        pc_load;
  logic [31:0] pc_vector;
  logic        in_isr;

  int checks = 0;
  int errors = 0;

  interrupt_unit #(.VECTOR_ADDR(32'h0000_0002), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .int_req(int_req), .pc_in(pc_in), .ccr_in(ccr_in),
    .freeze_cu(freeze_cu), .rti(rti), .mem_busy(mem_busy),
    .fetch_stall(fetch_stall), .push_en(push_en), .push_data(push_data),
    .pc_load(pc_load), .pc_vector(pc_vector), .in_isr(in_isr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic fs, input logic pe,
                         input logic [15:0] pd, input logic pl, input logic ii);
    logic [19:0] obs;
    logic [19:0] exp;
    obs = {fetch_stall, push_en, push_data, pc_load, in_isr};
    exp = {fs, pe, pd, pl, ii};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag);
    checks++;
    assert (pc_vector === 32'h0000_0002) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, pc_vector, 32'h0000_0002);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk_out(tag, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  // Expects the next edge to enter DRAIN; follows the unstalled sequence into ISR.
  task automatic expect_seq(input string tag);
    repeat (3) begin
      tick();
      chk_out({tag, "_drain"}, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    end
    tick(); chk_out({tag, "_pch"}, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);
    tick(); chk_out({tag, "_pcl"}, 1'b1, 1'b1, 16'h2345, 1'b0, 1'b0);
    tick(); chk_out({tag, "_ccr"}, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b0);
    tick(); chk_out({tag, "_load"}, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk_vec({tag, "_vec"});
    tick(); chk_out({tag, "_isr"}, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
  endtask

  task automatic pulse_req();
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
  endtask

  task automatic do_rti(input string tag);
    rti = 1'b1;
    tick();
    rti = 1'b0;
    chk_idle(tag);
  endtask

  initial begin
    rst = 1'b1; int_req = 1'b0; pc_in = 32'h0001_2345; ccr_in = 3'b101;
    freeze_cu = 1'b0; rti = 1'b0; mem_busy = 1'b0;
    #1;
    chk_idle("reset_outputs");
    chk_vec("reset_vector");
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    chk_idle("idle_after_reset");

    // Basic entry: request registered, one IDLE cycle, then the full sequence.
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    chk_idle("basic_pending_cycle");
    expect_seq("basic");
    tick(); chk_out("isr_hold", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    do_rti("basic_rti");

    // Freeze blocks entry for 4 cycles.
    freeze_cu = 1'b1;
    pulse_req();
    chk_idle("freeze_0");
    repeat (3) begin
      tick();
      chk_idle("freeze_hold");
    end
    freeze_cu = 1'b0;
    expect_seq("freeze");
    do_rti("freeze_rti");

    // mem_busy stretches PUSH_PCL by 2 cycles.
    pulse_req();
    repeat (3) begin
      tick();
      chk_out("busy_drain", 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    end
    tick(); chk_out("busy_pch", 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0);
    tick(); chk_out("busy_pcl0", 1'b1, 1'b1, 16'h2345, 1'b0, 1'b0);
    mem_busy = 1'b1;
    tick(); chk_out("busy_pcl1", 1'b1, 1'b1, 16'h2345, 1'b0, 1'b0);
    tick(); chk_out("busy_pcl2", 1'b1, 1'b1, 16'h2345, 1'b0, 1'b0);
    mem_busy = 1'b0;
    tick(); chk_out("busy_ccr", 1'b1, 1'b1, 16'h0005, 1'b0, 1'b0);
    tick(); chk_out("busy_load", 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick(); chk_out("busy_isr", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

    // Request during ISR stays pending, no nesting, serviced after RTI.
    pulse_req();
    chk_out("nest_masked0", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    repeat (2) begin
      tick();
      chk_out("nest_masked", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    end
    do_rti("nest_rti_idle");
    expect_seq("nest");

    // Request rising on the same edge as RTI.
    int_req = 1'b1;
    rti = 1'b1;
    tick();
    int_req = 1'b0;
    rti = 1'b0;
    chk_idle("race_idle");
    expect_seq("race");
    do_rti("race_rti");

    // RTI in IDLE is ignored.
    rti = 1'b1;
    tick();
    rti = 1'b0;
    chk_idle("rti_idle0");
    tick(); chk_idle("rti_idle1");

    // Reset in PUSH_PCL abandons the sequence.
    pulse_req();
    repeat (4) tick();
    tick(); chk_out("rst_pre_pcl", 1'b1, 1'b1, 16'h2345, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("rst_async");
    chk_vec("rst_async_vec");
    tick();
    rst = 1'b0;
    repeat (12) begin
      tick();
      chk_idle("rst_after_release");
    end

    // Request level held high through reset is not an edge.
    int_req = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (12) begin
      tick();
      chk_idle("held_level");
    end
    int_req = 1'b0;
    tick();
    chk_idle("held_fall");
    pulse_req();
    chk_idle("held_new_edge");
    expect_seq("held");
    do_rti("held_rti");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
